// File: rtl/d_latch_pkg.sv
// Shared definitions for the d_latch checker: FSM state encoding and default counter width.
package d_latch_pkg;

  localparam int CNT_W_DEF = 16;

  // Encoding 2'd3 is never entered on purpose; the FSM recovers it to UNINIT.
  typedef enum logic [1:0] {
    UNINIT      = 2'd0,
    TRANSPARENT = 2'd1,
    HOLD        = 2'd2
  } state_t;

endpackage

// File: rtl/d_latch_checker_sat_counter.sv
// Up-counter with increment enable that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/d_latch_checker.sv
// Clocked monitor comparing an observed d_latch output against a reference model.
// Optional first-error capture ports are enabled with D_LATCH_CHECKER_FIRST_ERR_EN.
module d_latch_checker
  import d_latch_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             D,
  input  logic             EN,
  input  logic             Q,
  input  logic             chk_en,
  output logic             err_pulse,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] check_count,
`ifdef D_LATCH_CHECKER_FIRST_ERR_EN
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_cycle,
  output logic [2:0]       first_err_snap,
`endif
  output logic [1:0]       state
);

  localparam logic [2:0] SETTLE_LD = 3'(SETTLE_CYCLES);

  logic   d_s, en_s, q_s;
  logic   d_prev, en_prev;
  logic   held;
  logic   [2:0] settle_q;
  state_t state_q, state_d;
  logic   change, eligible, do_check, exp_val, mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_s      <= 1'b0;
      en_s     <= 1'b0;
      q_s      <= 1'b0;
      d_prev   <= 1'b0;
      en_prev  <= 1'b0;
      settle_q <= 3'd0;
    end else begin
      d_s      <= D;
      en_s     <= EN;
      q_s      <= Q;
      d_prev   <= d_s;
      en_prev  <= en_s;
      if (change) begin
        settle_q <= SETTLE_LD;
      end else if (settle_q != 3'd0) begin
        settle_q <= settle_q - 3'd1;
      end
    end
  end

  assign change   = (d_s != d_prev) || (en_s != en_prev);
  assign eligible = (settle_q == 3'd0) && !change;

  // state_d is the mode implied by the current stage-1 sample; the check judges that sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      UNINIT:      if (en_s)  state_d = TRANSPARENT;
      TRANSPARENT: if (!en_s) state_d = HOLD;
      HOLD:        if (en_s)  state_d = TRANSPARENT;
      default:     state_d = UNINIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= UNINIT;
      held    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == TRANSPARENT) held <= d_s;
    end
  end

  assign exp_val  = (state_d == TRANSPARENT) ? d_s : held;
  assign do_check = eligible && chk_en && (state_d != UNINIT);
  assign mismatch = do_check && (q_s != exp_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err       <= 1'b0;
    end else begin
      err_pulse <= mismatch;
      if (mismatch) err <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_check_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (do_check),
    .count (check_count)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mismatch),
    .count (err_count)
  );

`ifdef D_LATCH_CHECKER_FIRST_ERR_EN
  // Cycle index is the check count before this check's own increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_err_valid <= 1'b0;
      first_err_cycle <= '0;
      first_err_snap  <= 3'b000;
    end else if (mismatch && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_cycle <= check_count;
      first_err_snap  <= {d_s, en_s, q_s};
    end
  end
`endif

  assign state = state_q;

endmodule

// File: tb/tb_d_latch_checker.sv
// Directed bench for d_latch_checker: three instances cover default, long settle and narrow counters.
module tb_d_latch_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Default instance driven through a behavioural latch with a fault override.
  logic d, en, lq, ovr, qv, q0, chk0;
  logic err_pulse0, err0;
  logic [15:0] err_count0, check_count0;
  logic [1:0] state0;
  always_latch if (en) lq <= d;
  assign q0 = ovr ? qv : lq;

  // SETTLE_CYCLES=3 instance.
  logic ds, ens, qsv;
  logic err_pulse_s, err_s;
  logic [15:0] err_count_s, check_count_s;
  logic [1:0] state_s;

  // CNT_W=4 instance.
  logic dc, enc, qc, chkc;
  logic err_pulse_c, err_c;
  logic [3:0] err_count_c, check_count_c;
  logic [1:0] state_c;

`ifdef D_LATCH_CHECKER_FIRST_ERR_EN
  logic fev0, fev_s, fev_c;
  logic [15:0] fec0, fec_s;
  logic [3:0] fec_c;
  logic [2:0] fes0, fes_s, fes_c;
`endif

  d_latch_checker dut0 (
    .clk(clk), .rst(rst), .D(d), .EN(en), .Q(q0), .chk_en(chk0),
    .err_pulse(err_pulse0), .err(err0), .err_count(err_count0), .check_count(check_count0),
`ifdef D_LATCH_CHECKER_FIRST_ERR_EN
    .first_err_valid(fev0), .first_err_cycle(fec0), .first_err_snap(fes0),
`endif
    .state(state0)
  );

  d_latch_checker #(.SETTLE_CYCLES(3)) dut_s (
    .clk(clk), .rst(rst), .D(ds), .EN(ens), .Q(qsv), .chk_en(1'b1),
    .err_pulse(err_pulse_s), .err(err_s), .err_count(err_count_s), .check_count(check_count_s),
`ifdef D_LATCH_CHECKER_FIRST_ERR_EN
    .first_err_valid(fev_s), .first_err_cycle(fec_s), .first_err_snap(fes_s),
`endif
    .state(state_s)
  );

  d_latch_checker #(.CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .D(dc), .EN(enc), .Q(qc), .chk_en(chkc),
    .err_pulse(err_pulse_c), .err(err_c), .err_count(err_count_c), .check_count(check_count_c),
`ifdef D_LATCH_CHECKER_FIRST_ERR_EN
    .first_err_valid(fev_c), .first_err_cycle(fec_c), .first_err_snap(fes_c),
`endif
    .state(state_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Returns one time unit after the n-th following rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    en = 1'b1; d = 1'b0; ovr = 1'b0; qv = 1'b0; chk0 = 1'b1;
    ds = 1'b0; ens = 1'b0; qsv = 1'b0;
    dc = 1'b0; enc = 1'b0; qc = 1'b0; chkc = 1'b1;
    #1 en = 1'b0;

    // Reset, then EN low with D toggling and Q wrong: stays UNINIT, nothing counted.
    do_reset();
    ovr = 1'b1; qv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = ~d;
      tick(1);
    end
    check("uninit_state", 32'(state0), 32'd0);
    check("uninit_checks", 32'(check_count0), 32'd0);
    check("uninit_errs", 32'(err_count0), 32'd0);
    check("uninit_err", 32'(err0), 32'd0);
    ovr = 1'b0; d = 1'b0;
    do_reset();

    // Correct transparent/hold sequence: 40 samples, 4 changes x 2 suppressed.
    en = 1'b1; d = 1'b0; tick(10);
    d = 1'b1; tick(10);
    d = 1'b0; tick(10);
    en = 1'b0; d = 1'b1; tick(10);
    tick(1);
    check("good_checks", 32'(check_count0), 32'd32);
    check("good_err", 32'(err0), 32'd0);
    check("good_state", 32'(state0), 32'd2);

    // Hold fault: Q forced high for three samples while held value is 0.
    ovr = 1'b1; qv = 1'b1;
    tick(1); check("hold_pulse_pre", 32'(err_pulse0), 32'd0);
    tick(1); check("hold_pulse_1", 32'(err_pulse0), 32'd1);
    tick(1); check("hold_pulse_2", 32'(err_pulse0), 32'd1);
    ovr = 1'b0;
    tick(1); check("hold_pulse_3", 32'(err_pulse0), 32'd1);
    tick(1); check("hold_pulse_post", 32'(err_pulse0), 32'd0);
    check("hold_errs", 32'(err_count0), 32'd3);
    check("hold_err_sticky", 32'(err0), 32'd1);
    check("hold_checks", 32'(check_count0), 32'd37);

    // chk_en low with a persistent mismatch: no pulses, counts frozen.
    chk0 = 1'b0; ovr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) ovr = 1'b0;
      tick(1);
      check("gate_pulse", 32'(err_pulse0), 32'd0);
    end
    check("gate_checks", 32'(check_count0), 32'd37);
    check("gate_errs", 32'(err_count0), 32'd3);
    chk0 = 1'b1;
    tick(1);
    check("reenable_checks", 32'(check_count0), 32'd38);
    check("reenable_pulse", 32'(err_pulse0), 32'd0);

    // Asynchronous reset clears state without a clock edge.
    rst = 1'b1;
    #2;
    check("async_state", 32'(state0), 32'd0);
    check("async_checks", 32'(check_count0), 32'd0);
    check("async_err", 32'(err0), 32'd0);
    #1 rst = 1'b0;
    ovr = 1'b1; qv = 1'b1;
    tick(5);
    check("post_rst_nocheck", 32'(check_count0), 32'd0);
    check("post_rst_noerr", 32'(err_count0), 32'd0);
    ovr = 1'b0;

    // SETTLE_CYCLES=3: Q lags D by two samples, hidden by the settle window.
    do_reset();
    ens = 1'b1; ds = 1'b0; qsv = 1'b0; tick(10);
    ds = 1'b1; tick(2);
    qsv = 1'b1; tick(8);
    tick(1);
    check("settle_checks", 32'(check_count_s), 32'd12);
    check("settle_err", 32'(err_s), 32'd0);

    // CNT_W=4: persistent mismatch saturates both counters at 15.
    do_reset();
    enc = 1'b1; dc = 1'b0; qc = 1'b1;
    tick(10);
    check("sat_errs_mid", 32'(err_count_c), 32'd7);
    tick(13);
    check("sat_errs", 32'(err_count_c), 32'd15);
    check("sat_checks", 32'(check_count_c), 32'd15);
    check("sat_pulse", 32'(err_pulse_c), 32'd1);
    chkc = 1'b0;
    tick(5);
    check("sat_gate_errs", 32'(err_count_c), 32'd15);
    check("sat_gate_pulse", 32'(err_pulse_c), 32'd0);

`ifdef D_LATCH_CHECKER_FIRST_ERR_EN
    // First mismatch on the eighth check (index 7) with D=1, EN=1, Q=0.
    do_reset();
    en = 1'b1; d = 1'b1; ovr = 1'b0; chk0 = 1'b1;
    tick(9);
    ovr = 1'b1; qv = 1'b0;
    tick(2);
    check("first_valid", 32'(fev0), 32'd1);
    check("first_cycle", 32'(fec0), 32'd7);
    check("first_snap", 32'(fes0), 32'd6);
    tick(2);
    check("first_cycle_held", 32'(fec0), 32'd7);
    check("first_snap_held", 32'(fes0), 32'd6);
    check("first_later_errs", 32'(err_count0), 32'd3);
    ovr = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/d_latch_checker.md
# d_latch_checker

Clocked, synthesizable monitor for the observing end of the `d_latch` interface. It samples `D`, `EN` and `Q` on every `clk` rising edge and keeps its own expected-value model of the latch. It flags any cycle where `Q` disagrees with that model and keeps saturating counts of checks and errors. It sits beside a `d_latch` instance, in a bench or on-chip, as the self-checking counterpart of the stimulus driver.

## Interface
Parameters:
- `CNT_W`, default 16: width of `check_count` and `err_count`.
- `SETTLE_CYCLES`, default 1: number of samples suppressed after any change on `D` or `EN`. Legal range 0–7.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `D`  input  1  latch data input, observed.
- `EN`  input  1  latch enable, observed.
- `Q`  input  1  latch output, observed.
- `chk_en`  input  1  global check enable; 0 suppresses checking and counting.
- `err_pulse`  output  1  one-cycle pulse per detected mismatch.
- `err`  output  1  sticky error flag; cleared only by `rst`.
- `err_count`  output  `CNT_W`  saturating mismatch count.
- `check_count`  output  `CNT_W`  saturating count of performed checks.
- `state`  output  2  current FSM state, for debug.

## Operation
- Input sampling:
  - Stage 1 (`d_s`, `en_s`, `q_s`) registers `D`, `EN`, `Q` each edge.
  - Stage 2 holds the previous stage-1 `d_s` and `en_s`.
  - Change = `d_s != d_prev` or `en_s != en_prev`.
- Settle counter:
  - On a change, loads `SETTLE_CYCLES`; otherwise decrements to 0.
  - A check is eligible only when the counter is 0 and there is no change this cycle.
  - With `SETTLE_CYCLES`=0, every sample without a change is eligible.
- FSM states:
  - UNINIT (0): after reset; hold value unknown.
  - TRANSPARENT (1): `en_s`=1.
  - HOLD (2): `en_s`=0 after at least one transparent sample.
  - Encoding 3 is unused and recovers to UNINIT.
- FSM transitions:
  - UNINIT→TRANSPARENT on `en_s`=1; UNINIT stays while `en_s`=0.
  - TRANSPARENT→HOLD on `en_s`=0.
  - HOLD→TRANSPARENT on `en_s`=1.
- Expected model:
  - In TRANSPARENT, expected = `d_s` and `held` ← `d_s`.
  - In HOLD, expected = `held`.
  - In UNINIT, no check is performed.
- Check:
  - Performed when eligible, `chk_en`=1 and state ≠ UNINIT.
  - Each check increments `check_count`.
  - A mismatch between `q_s` and expected also asserts `err_pulse`, sets `err` and increments `err_count`.
  - Counters saturate at all-ones and never wrap.
- `chk_en`=0: the FSM and `held` keep tracking the inputs; counters and flags are frozen.

## Timing
- Reset values: `err_pulse`=0, `err`=0, `err_count`=0, `check_count`=0, `state`=UNINIT. Stage registers, `held` and the settle counter are also 0.
- Latency: an input value present at edge k lands in stage 1 at edge k. The resulting `err_pulse` and counter updates are visible after edge k+1.
- `err_pulse` is high for exactly one cycle per mismatching check. Consecutive mismatching checks give back-to-back pulses.
- `rst` asserted mid-operation clears all state immediately, with no clock needed. The first check after reset requires a fresh transparent sample.
- `D` and `EN` changing on the same edge count as one change event.

## Configuration
- `D_LATCH_CHECKER_FIRST_ERR_EN` defined:
  - Adds outputs `first_err_valid` (1 bit), `first_err_cycle` (`CNT_W`) and `first_err_snap` (3 bits: `d_s`, `en_s`, `q_s`).
  - Captured on the first mismatch after reset and held until `rst`.
  - `first_err_cycle` is the `check_count` value at that check, before its increment.
  - All three reset to 0.
- Not defined: these ports and registers are absent; all other behaviour is identical.

## Structure
- Shared package `d_latch_pkg`: state encoding constants (UNINIT, TRANSPARENT, HOLD) and the default `CNT_W`.
- One sub-module, `sat_counter`:
  - Parameterized width, with inc enable, async `rst` and saturation at all-ones.
  - Instantiated twice, for `check_count` and `err_count`.

## Test plan
- **Reset:** `rst` pulse with `EN`=0 and `D` toggling → `state`=0 and all counts 0; no checks while in UNINIT.
- **Correct transparent/hold:**
  - Drive a real `d_latch`: `EN`=1, `D` 0→1→0, then `EN`=0, `D`=1, each held 10 cycles (`SETTLE_CYCLES`=1).
  - Expect `err`=0 and `check_count`=32: 4 changes, each suppressing 2 samples.
- **Injected hold fault:**
  - Force `Q`=1 while in HOLD with `held`=0 for 3 cycles.
  - Expect 3 consecutive `err_pulse`, `err_count`=3 and `err`=1 after the fault is removed.
- **Settle window:** with `SETTLE_CYCLES`=3, `Q` lags `D` by 2 cycles after a `D` change → no error.
- **Saturation and gating:**
  - With `CNT_W`=4 and persistent mismatch for 20 checks, expect `err_count`=15 and holding.
  - Then `chk_en`=0 for 5 cycles → counters unchanged.
- **First-error capture (macro defined):** first mismatch at check 7 with `D`=1, `EN`=1, `Q`=0 → `first_err_valid`=1, `first_err_cycle`=7, `first_err_snap`=3'b110, unchanged by later errors.
